// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter -- multi-cycle barrel-less shifter for the MIPS_32 execute stage.
//
// The operand is loaded into the working register on accept. Each SHIFT cycle
// then moves it by up to STEP bits until the requested amount is used up, so
// latency grows with the shift amount and the per-cycle shifter stays small.
//
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN
//   defined   : mode 2'b11 rotates right
//   undefined : mode 2'b11 decodes as SLL and no rotate logic is built
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   start      request, taken when start && in_ready
//   in_ready   high in IDLE
//   a          operand (sampled on accept)
//   shamt      shift amount (sampled on accept)
//   mode       00 SLL, 01 SRL, 10 SRA, 11 ROTR/SLL (sampled on accept)
//   busy       high in SHIFT and DONE
//   out_valid  high in DONE
//   out_ready  consumer takes the result
//   outS       working/result register
// ---------------------------------------------------------------------------
module seq_shifter #(
  parameter int SIZE    = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               in_ready,
  input  logic [SIZE-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE-1:0]    outS
);

  // One extra bit so STEP and SIZE (each up to 2^SHAMT_W) are representable.
  localparam int AW = SHAMT_W + 1;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [AW-1:0] SIZE_A = AW'(SIZE);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SIZE-1:0]    outs_q, outs_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;

  logic [AW-1:0]      rem_ext;
  logic [AW-1:0]      amt;
  logic [SIZE-1:0]    step_res;

  // Amount consumed this cycle: min(STEP, remaining).
  always_comb begin
    rem_ext = {1'b0, rem_q};
    amt     = (rem_ext < STEP_A) ? rem_ext : STEP_A;
  end

  // Single-step shift of the working register by amt.
  always_comb begin
    step_res = outs_q << amt;
    case (mode_q)
      2'b01:   step_res = outs_q >> amt;
      // MSB is never altered by an arithmetic right shift, so the sign
      // survives every iteration.
      2'b10:   step_res = $unsigned($signed(outs_q) >>> amt);
`ifdef SEQ_SHIFTER_ROTATE_EN
      // amt is 1..STEP in SHIFT, so SIZE-amt never exceeds SIZE-1.
      2'b11:   step_res = (outs_q >> amt) | (outs_q << (SIZE_A - amt));
`endif
      default: step_res = outs_q << amt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    outs_d  = outs_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          outs_d  = a;
          rem_d   = shamt;
          mode_d  = mode;
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        outs_d = step_res;
        // amt <= rem_q, so the difference always fits in SHAMT_W bits.
        rem_d  = SHAMT_W'(rem_ext - amt);
        if (rem_ext <= STEP_A) state_d = DONE;
      end
      DONE: begin
        // start is deliberately ignored here, even alongside out_ready.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      outs_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign outS      = outs_q;

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter -- self-checking bench for seq_shifter (default parameters).
// Directed vector table, hand-written backpressure / reset sequences, then
// random operations checked against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_shifter;

  localparam int SIZE    = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_ready;
  logic [SIZE-1:0]   a = '0;
  logic [SHAMT_W-1:0] shamt = '0;
  logic [1:0]        mode = 2'b00;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SIZE-1:0]   outS;

  int n_chk  = 0;
  int n_fail = 0;

  seq_shifter #(.SIZE(SIZE), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .a(a), .shamt(shamt), .mode(mode), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .outS(outS)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: whole-shift arithmetic, independent of step size.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int sh, input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'b01: r = x >> sh;
      2'b10: r = $unsigned($signed(x) >>> sh);
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11: r = (sh % 32 == 0) ? x : ((x >> (sh % 32)) | (x << (32 - sh % 32)));
`endif
      default: r = x << sh;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input int sh);
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  // Issue one request and wait for out_valid. Returns cycles from the
  // accept edge (accept edge counts as 1) and leaves the DUT in DONE.
  task automatic issue(input logic [31:0] ai, input logic [4:0] si, input logic [1:0] mi,
                       output int lat);
    @(negedge clk);
    check("in_ready before accept", {31'd0, in_ready}, 32'd1);
    a = ai; shamt = si; mode = mi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble operands: in-flight op must not see them
    a = ~ai; shamt = ~si; mode = ~mi;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready after handoff", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held, ra;
    logic [4:0]  rs;
    logic [1:0]  rm;

    vecs[0] = '{32'h8000_0001, 5'd4,  2'b00, 32'h0000_0010, 2};
    vecs[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 9};
    vecs[2] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9};
    vecs[3] = '{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 1};
    vecs[4] = '{32'h0000_0100, 5'd5,  2'b01, 32'h0000_0008, 3};
`ifdef SEQ_SHIFTER_ROTATE_EN
    vecs[5] = '{32'h0000_000F, 5'd4,  2'b11, 32'hF000_0000, 2};
`else
    vecs[5] = '{32'h0000_000F, 5'd4,  2'b11, 32'h0000_00F0, 2};
`endif
    vecs[6] = '{32'hF000_0000, 5'd8,  2'b10, 32'hFFF0_0000, 3};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outS", outS, 32'h0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].shamt, vecs[i].mode, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d outS", i), outS, vecs[i].exp);
      check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd1);
      handoff();
      check($sformatf("vec%0d outS retained", i), outS, vecs[i].exp);
    end

    // backpressure: start pulsed with new operands while DONE is stalled
    issue(32'h8000_0001, 5'd4, 2'b00, lat);
    held = outS;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = ~start;
      a = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
      @(posedge clk); #1;
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall outS", outS, held);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;   // start alongside out_ready is ignored
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    check("release in_ready", {31'd0, in_ready}, 32'd1);
    check("release out_valid", {31'd0, out_valid}, 32'd0);
    check("release outS", outS, held);

    // reset on the 3rd cycle of a shamt=31 op
    @(negedge clk);
    a = 32'h8000_0000; shamt = 5'd31; mode = 2'b10; start = 1'b1;
    @(posedge clk); #1;          // accept
    start = 1'b0;
    @(posedge clk); #1;          // 2nd cycle
    rst = 1'b1;
    @(posedge clk); #1;          // 3rd cycle edge with rst
    rst = 1'b0;
    check("midrst outS", outS, 32'h0);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    issue(32'h0000_0100, 5'd5, 2'b01, lat);
    check("post-reset latency", lat, 3);
    check("post-reset outS", outS, 32'h0000_0008);
    handoff();

    // random ops vs reference model, with random DONE stalls
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rs = 5'($urandom); rm = 2'($urandom);
      issue(ra, rs, rm, lat);
      check($sformatf("rand%0d latency", i), lat, ref_lat(int'(rs)));
      check($sformatf("rand%0d outS", i), outS, ref_shift(ra, int'(rs), rm));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check($sformatf("rand%0d stall outS", i), outS, ref_shift(ra, int'(rs), rm));
      end
      handoff();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
